// File: rtl/op_enc_pkg.sv
// ============================================================================
// Module   : op_enc_pkg
// Brief    : Shared opcodes, default power-on packet and packet-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package op_enc_pkg;

    localparam logic [7:0]  OP_KBD            = 8'hC6;
    localparam logic [7:0]  OP_MIC            = 8'hC7;
    localparam logic [7:0]  KBD_SUB           = 8'h10;
    localparam logic [7:0]  MOUSE_SUB         = 8'h01;
    localparam logic [39:0] PWRON_PKT_DEFAULT = 40'hC671000000;

    function automatic int pkt_w(input int payload_w);
        return 8 + payload_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_enc_fifo.sv
// ============================================================================
// Module   : op_enc_fifo
// Brief    : Single-channel synchronous FIFO holding {opcode, payload} beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_enc_fifo
    import op_enc_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    parameter int DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [pkt_w(PAYLOAD_W)-1:0]      wr_data,
    output logic [pkt_w(PAYLOAD_W)-1:0]      rd_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           level
);

    localparam int W  = pkt_w(PAYLOAD_W);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Push is refused on a full FIFO even when a pop happens in the same cycle.
    assign full   = (r_count == LW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_count;

endmodule

`default_nettype wire

// File: rtl/op_encoder_arb.sv
// ============================================================================
// Module   : op_encoder_arb
// Brief    : Multi-channel packet encoder with per-channel FIFOs, power-on
//            packet priority and fixed/round-robin arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_encoder_arb
    import op_enc_pkg::*;
#(
    parameter int                            NUM_CH         = 3,
    parameter int                            PAYLOAD_W      = 32,
    parameter int                            FIFO_DEPTH     = 4,
    parameter bit                            RR_EN          = 1'b1,
    parameter bit                            PWRON_AT_RESET = 1'b1,
    parameter logic [pkt_w(PAYLOAD_W)-1:0]   PWRON_PKT      = PWRON_PKT_DEFAULT
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       power_on_req,
    input  logic [NUM_CH-1:0]                          src_valid,
    output logic [NUM_CH-1:0]                          src_ready,
    input  logic [NUM_CH*8-1:0]                        src_opcode,
    input  logic [NUM_CH*PAYLOAD_W-1:0]                src_data,
    output logic [pkt_w(PAYLOAD_W)-1:0]                out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]   fifo_level
);

    localparam int PKT_W = pkt_w(PAYLOAD_W);
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][PKT_W-1:0] w_head;
    logic [NUM_CH-1:0]            w_full;
    logic [NUM_CH-1:0]            w_empty;
    logic [NUM_CH-1:0]            w_pop_oh;
    logic [GW-1:0]                w_grant;
    logic                         w_any;
    logic                         w_load;
    logic                         w_pop;
    int                           w_idx;

    logic [PKT_W-1:0]             r_out_data;
    logic                         r_out_valid;
    logic                         r_pwr_pending;
    logic [GW-1:0]                r_last_grant;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            op_enc_fifo #(
                .PAYLOAD_W (PAYLOAD_W),
                .DEPTH     (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push    (src_valid[i]),
                .pop     (w_pop_oh[i]),
                .wr_data ({src_opcode[8*i +: 8], src_data[PAYLOAD_W*i +: PAYLOAD_W]}),
                .rd_data (w_head[i]),
                .full    (w_full[i]),
                .empty   (w_empty[i]),
                .level   (fifo_level[LW*i +: LW])
            );
            assign src_ready[i] = ~w_full[i];
            assign w_pop_oh[i]  = w_pop & (w_grant == GW'(i));
        end
    endgenerate

    // Arbitration sees only pre-edge FIFO contents; same-edge pushes are invisible.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_EN) begin
                w_idx = (int'(r_last_grant) + 1 + k) % NUM_CH;
            end else begin
                w_idx = k;
            end
            if (!w_any && !w_empty[w_idx]) begin
                w_any   = 1'b1;
                w_grant = GW'(w_idx);
            end
        end
    end

    assign w_load = ~r_out_valid | out_ready;
    assign w_pop  = w_load & ~r_pwr_pending & w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_pwr_pending <= PWRON_AT_RESET;
            r_last_grant  <= GW'(NUM_CH - 1);
        end else begin
            if (w_load) begin
                if (r_pwr_pending) begin
                    r_out_data  <= PWRON_PKT;
                    r_out_valid <= 1'b1;
                end else if (w_any) begin
                    r_out_data   <= w_head[w_grant];
                    r_out_valid  <= 1'b1;
                    r_last_grant <= w_grant;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end
            // A request coinciding with a power-on load re-arms for one more packet.
            r_pwr_pending <= power_on_req | (r_pwr_pending & ~w_load);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire
